// File: rtl/ip_fetch_seq.sv
// ip_fetch_seq: drives the IP counter (step strobe + direction), registers the IP
// as the program ROM address and delivers the landed instruction to the executor.
// Supports plain fetch, single step and bracket-matching scans in both directions.
// Optional feature macro: IP_BOUND_CHECK_EN (scans stop with Err at the IP range ends).
module ip_fetch_seq #(
    parameter int         ROM_LAT    = 1,
    parameter int         DEPTH_W    = 8,
    parameter logic [3:0] OPEN_CODE  = 4'hE,
    parameter logic [3:0] CLOSE_CODE = 4'hF
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [1:0]  Cmd,
    input  logic        Cmd_valid,
    output logic        Cmd_ready,
    output logic        IpStep,
    output logic        IpReverse,
    input  logic        IpReady,
    input  logic [17:0] Ip,
    output logic [17:0] RomAddr,
    input  logic [3:0]  RomData,
    output logic [3:0]  Insn,
    output logic        Insn_valid,
    output logic        Err
);

    localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_STEP, S_WAIT_IP, S_WAIT_ROM, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t               state, state_nxt;
    logic                 scan_q;
    logic                 rev_q;
    logic [DEPTH_W-1:0]   depth_q, depth_nxt;
    logic [17:0]          rom_addr_q;
    logic [CNT_W-1:0]     rom_cnt_q;
    logic [3:0]           rom_data_q;
    logic [3:0]           insn_q;
    logic                 err_q;
    logic                 settle_q;
    logic                 set_err;
    logic                 at_bound;
    logic                 nest_in, nest_out;

`ifdef IP_BOUND_CHECK_EN
    // A scan must not step past either end of the IP range.
    assign at_bound = scan_q && ((!rev_q && Ip == 18'o777777) || (rev_q && Ip == 18'o0));
`else
    assign at_bound = 1'b0;
`endif

    // Bracket direction depends on scan direction: forward nests on '[', backward on ']'.
    assign nest_in  = rev_q ? (rom_data_q == CLOSE_CODE) : (rom_data_q == OPEN_CODE);
    assign nest_out = rev_q ? (rom_data_q == OPEN_CODE)  : (rom_data_q == CLOSE_CODE);

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state, strobes, depth update and error detection.
    always_comb begin
        state_nxt  = state;
        depth_nxt  = depth_q;
        Cmd_ready  = 1'b0;
        IpStep     = 1'b0;
        Insn_valid = 1'b0;
        set_err    = 1'b0;
        case (state)
            S_IDLE: begin
                Cmd_ready = 1'b1;
                if (Cmd_valid) begin
                    state_nxt = (Cmd == 2'b00) ? S_WAIT_IP : S_STEP;
                    depth_nxt = Cmd[1] ? DEPTH_W'(1) : '0;
                end
            end
            S_STEP: begin
                if (IpReady) begin
                    if (at_bound) begin
                        set_err   = 1'b1;
                        state_nxt = S_ERR;
                    end else begin
                        IpStep    = 1'b1;
                        state_nxt = S_WAIT_IP;
                    end
                end
            end
            S_WAIT_IP: begin
                // First cycle is skipped so the counter can absorb the step.
                if (!settle_q && IpReady) state_nxt = S_WAIT_ROM;
            end
            S_WAIT_ROM: begin
                if (rom_cnt_q == CNT_W'(ROM_LAT - 1)) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (!scan_q) begin
                    state_nxt = S_DONE;
                end else begin
                    if (nest_in) begin
                        if (&depth_q) set_err = 1'b1;
                        else          depth_nxt = depth_q + DEPTH_W'(1);
                    end else if (nest_out) begin
                        depth_nxt = (depth_q == '0) ? '0 : depth_q - DEPTH_W'(1);
                    end
                    if (set_err)               state_nxt = S_ERR;
                    else if (depth_nxt == '0)  state_nxt = S_DONE;
                    else                       state_nxt = S_STEP;
                end
            end
            S_DONE: begin
                Insn_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command capture, address/data registers, latency counter and sticky error.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            scan_q     <= 1'b0;
            rev_q      <= 1'b0;
            depth_q    <= '0;
            rom_addr_q <= '0;
            rom_cnt_q  <= '0;
            rom_data_q <= '0;
            insn_q     <= '0;
            err_q      <= 1'b0;
            settle_q   <= 1'b0;
        end else begin
            if (state == S_IDLE && Cmd_valid) begin
                scan_q <= Cmd[1];
                if (Cmd != 2'b00) rev_q <= (Cmd == 2'b11);
            end
            depth_q  <= depth_nxt;
            settle_q <= (state_nxt == S_WAIT_IP) && (state != S_WAIT_IP);
            if (state == S_WAIT_IP && state_nxt == S_WAIT_ROM) begin
                rom_addr_q <= Ip;
                rom_cnt_q  <= '0;
            end else if (state == S_WAIT_ROM) begin
                rom_cnt_q  <= rom_cnt_q + CNT_W'(1);
            end
            if (state == S_WAIT_ROM && state_nxt == S_CHECK) rom_data_q <= RomData;
            if (state == S_CHECK && state_nxt == S_DONE)     insn_q     <= rom_data_q;
            if (set_err) err_q <= 1'b1;
        end
    end

    assign IpReverse = rev_q;
    assign RomAddr   = rom_addr_q;
    assign Insn      = insn_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_ip_fetch_seq.sv
// Directed bench for ip_fetch_seq with a behavioural IP counter and a small ROM.
module tb_ip_fetch_seq;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [1:0]  Cmd = 2'b00;
    logic        Cmd_valid = 1'b0;
    logic        Cmd_ready;
    logic        IpStep;
    logic        IpReverse;
    logic        IpReady = 1'b1;
    logic [17:0] Ip = '0;
    logic [17:0] RomAddr;
    logic [3:0]  RomData;
    logic [3:0]  Insn;
    logic        Insn_valid;
    logic        Err;

    logic [3:0]  rom [0:63];
    logic        ld = 1'b0;
    logic [17:0] ld_val = '0;
    logic        exp_rev = 1'b0;
    int          step_total = 0;
    int          rev_bad_total = 0;
    int          vectors = 0;
    int          miscompares = 0;

    ip_fetch_seq dut (
        .Clk(Clk), .Rst_n(Rst_n), .Cmd(Cmd), .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready),
        .IpStep(IpStep), .IpReverse(IpReverse), .IpReady(IpReady), .Ip(Ip),
        .RomAddr(RomAddr), .RomData(RomData), .Insn(Insn), .Insn_valid(Insn_valid), .Err(Err)
    );

    always #5 Clk = ~Clk;

    assign RomData = rom[RomAddr[5:0]];

    // IP counter model: plain binary step keeps octal-digit encoding intact.
    always @(posedge Clk) begin
        if (ld)          Ip <= ld_val;
        else if (IpStep) Ip <= IpReverse ? Ip - 18'd1 : Ip + 18'd1;
    end

    // Count step pulses and direction errors mid-cycle.
    always @(negedge Clk) begin
        if (IpStep === 1'b1) begin
            step_total <= step_total + 1;
            if (IpReverse !== exp_rev) rev_bad_total <= rev_bad_total + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ip(input logic [17:0] v);
        @(negedge Clk);
        ld = 1'b1; ld_val = v;
        @(posedge Clk); #1;
        ld = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic run_cmd(input logic [1:0] c, input logic rev, output int lat,
                           output int steps, output int rbad);
        int s0, r0;
        @(negedge Clk);
        exp_rev = rev; Cmd = c; Cmd_valid = 1'b1;
        s0 = step_total; r0 = rev_bad_total;
        @(posedge Clk); #1;
        Cmd_valid = 1'b0;
        lat = 0;
        while (Insn_valid !== 1'b1 && lat < 4000) begin
            @(posedge Clk); #1;
            lat++;
        end
        @(negedge Clk);
        steps = step_total - s0;
        rbad  = rev_bad_total - r0;
    endtask

    initial begin
        int lat, steps, rbad, s0, n;
        for (int i = 0; i < 64; i++) rom[i] = 4'h0;

        // Reset values
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check_val("rst_ready", Cmd_ready, 1);
        check_val("rst_step", IpStep, 0);
        check_val("rst_rev", IpReverse, 0);
        check_val("rst_addr", RomAddr, 0);
        check_val("rst_insn", Insn, 0);
        check_val("rst_valid", Insn_valid, 0);
        check_val("rst_err", Err, 0);

        // FETCH at IP 0: latency 1+1+1+1
        rom[0] = 4'h1;
        set_ip(18'o0);
        run_cmd(2'b00, 1'b0, lat, steps, rbad);
        check_val("fetch_lat", lat, 4);
        check_val("fetch_steps", steps, 0);
        check_val("fetch_insn", Insn, 4'h1);
        check_val("fetch_addr", RomAddr, 0);

        // STEP from 0o7 to 0o10
        rom[8] = 4'h9;
        set_ip(18'o7);
        run_cmd(2'b01, 1'b0, lat, steps, rbad);
        check_val("step_lat", lat, 5);
        check_val("step_steps", steps, 1);
        check_val("step_rev", rbad, 0);
        check_val("step_addr", RomAddr, 18'o10);
        check_val("step_insn", Insn, 4'h9);

        // Program "[ [ x ] x ]" forward scan
        rom[0] = 4'hE; rom[1] = 4'hE; rom[2] = 4'h3;
        rom[3] = 4'hF; rom[4] = 4'h2; rom[5] = 4'hF;
        set_ip(18'o0);
        run_cmd(2'b10, 1'b0, lat, steps, rbad);
        check_val("fwd_steps", steps, 5);
        check_val("fwd_rev", rbad, 0);
        check_val("fwd_addr", RomAddr, 5);
        check_val("fwd_insn", Insn, 4'hF);
        check_val("fwd_err", Err, 0);

        // Same program, backward scan from 5
        set_ip(18'o5);
        run_cmd(2'b11, 1'b1, lat, steps, rbad);
        check_val("back_steps", steps, 5);
        check_val("back_rev", rbad, 0);
        check_val("back_dir", IpReverse, 1);
        check_val("back_addr", RomAddr, 0);
        check_val("back_insn", Insn, 4'hE);

        // IpReady low for 10 cycles while waiting for the IP
        rom[9] = 4'h6;
        set_ip(18'o10);
        @(negedge Clk);
        exp_rev = 1'b0; Cmd = 2'b01; Cmd_valid = 1'b1; s0 = step_total;
        @(posedge Clk); #1;
        Cmd_valid = 1'b0;
        @(posedge Clk); #1;
        IpReady = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        check_val("stall_addr", RomAddr, 0);
        check_val("stall_steps", step_total - s0, 1);
        check_val("stall_valid", Insn_valid, 0);
        IpReady = 1'b1;
        n = 0;
        while (Insn_valid !== 1'b1 && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        check_val("stall_done", Insn_valid, 1);
        check_val("stall_addr2", RomAddr, 18'o11);
        check_val("stall_insn", Insn, 4'h6);
        check_val("stall_steps2", step_total - s0, 1);

        // Backward scan from IP 0 hits the range boundary
        rom[0] = 4'hF; rom[63] = 4'hE;
        set_ip(18'o0);
`ifdef IP_BOUND_CHECK_EN
        @(negedge Clk);
        exp_rev = 1'b1; Cmd = 2'b11; Cmd_valid = 1'b1; s0 = step_total;
        @(posedge Clk); #1;
        Cmd_valid = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        check_val("bound_err", Err, 1);
        check_val("bound_ready", Cmd_ready, 0);
        check_val("bound_steps", step_total - s0, 0);
`else
        run_cmd(2'b11, 1'b1, lat, steps, rbad);
        check_val("wrap_steps", steps, 1);
        check_val("wrap_addr", RomAddr, 18'o777777);
        check_val("wrap_insn", Insn, 4'hE);
        check_val("wrap_err", Err, 0);
`endif
        apply_reset();
        check_val("rst2_err", Err, 0);
        check_val("rst2_ready", Cmd_ready, 1);

        // Depth overflow: all-'[' program scanned forward
        for (int i = 0; i < 64; i++) rom[i] = 4'hE;
        set_ip(18'o0);
        @(negedge Clk);
        exp_rev = 1'b0; Cmd = 2'b10; Cmd_valid = 1'b1; s0 = step_total;
        @(posedge Clk); #1;
        Cmd_valid = 1'b0;
        n = 0;
        while (Err !== 1'b1 && n < 3000) begin
            @(posedge Clk); #1;
            n++;
        end
        check_val("ovf_err", Err, 1);
        @(negedge Clk);
        Cmd = 2'b00; Cmd_valid = 1'b1;
        repeat (5) @(negedge Clk);
        check_val("ovf_ready", Cmd_ready, 0);
        check_val("ovf_valid", Insn_valid, 0);
        check_val("ovf_steps", step_total - s0, 255);
        Cmd_valid = 1'b0;
        apply_reset();
        check_val("rst3_err", Err, 0);
        check_val("rst3_ready", Cmd_ready, 1);
        check_val("rst3_addr", RomAddr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
